// File: rtl/sample_fifo_pkg.sv
// rtl/sample_fifo_pkg.sv - shared helpers for the sample FIFO
package sample_fifo_pkg;

  // Read-mode encodings for the FWFT parameter
  localparam int MODE_STANDARD = 0;
  localparam int MODE_FWFT     = 1;

  // True when the almost-full/almost-empty thresholds fit the FIFO depth
  function automatic bit thresholds_legal(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

  // True when the read-mode selector names a supported mode
  function automatic bit mode_legal(input int mode);
    return (mode == MODE_STANDARD) || (mode == MODE_FWFT);
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// rtl/sample_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read port
module sample_fifo_mem #(
  parameter int WIDTH    = 8,
  parameter int DEPTHBIT = 2
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [DEPTHBIT-1:0] wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [DEPTHBIT-1:0] rd_addr,
  output logic [WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 1 << DEPTHBIT;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - parametrised sync FIFO with FWFT option, thresholds and sticky errors
import sample_fifo_pkg::*;

module sample_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTHBIT  = 2,
  parameter int AF_THRESH = (1 << DEPTHBIT) - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [DEPTHBIT:0] level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << DEPTHBIT;
  localparam int PTRW  = DEPTHBIT + 1;

  localparam logic [PTRW-1:0] DEPTH_L = PTRW'(DEPTH);
  localparam logic [PTRW-1:0] AF_L    = PTRW'(AF_THRESH);
  localparam logic [PTRW-1:0] AE_L    = PTRW'(AE_THRESH);

  // Reject thresholds or modes that cannot be honoured for this depth
  if (!thresholds_legal(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("sample_fifo: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end
  if (!mode_legal(FWFT)) begin : g_bad_mode
    $error("sample_fifo: FWFT must be 0 or 1");
  end

  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] head_data;

  // Occupancy and flags come only from registered pointers
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_empty = (level <= AE_L);
  assign almost_full  = (level >= AF_L);

  // Flush swallows both requests; full/empty gate each side independently
  assign wr_acc = wr_en & ~full  & ~flush & ~rst;
  assign rd_acc = rd_en & ~empty & ~flush & ~rst;

  sample_fifo_mem #(
    .WIDTH    (WIDTH),
    .DEPTHBIT (DEPTHBIT)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[DEPTHBIT-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[DEPTHBIT-1:0]),
    .rd_data (head_data)
  );

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags: a new error beats a same-cycle clear, flush never sets them
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!flush && wr_en && full) overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
      if (!flush && rd_en && empty) underflow <= 1'b1;
      else if (clr_err)             underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; rd_en acts as a pop acknowledge
    assign rd_data  = head_data;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Registered read: data lands one cycle after the accepting edge
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= head_data;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sample_fifo.sv
// tb/tb_sample_fifo.sv - scoreboard bench driving standard and FWFT FIFOs in lockstep
module tb_sample_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic       empty0, empty1, full0, full1;
  logic       ae0, ae1, af0, af1;
  logic [2:0] level0, level1;
  logic       ov0, ov1, un0, un1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_fifo #(.WIDTH(8), .DEPTHBIT(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .level(level0), .overflow(ov0),
    .underflow(un0), .clr_err(clr_err)
  );

  sample_fifo #(.WIDTH(8), .DEPTHBIT(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .level(level1), .overflow(ov1),
    .underflow(un1), .clr_err(clr_err)
  );

  // Reference model: contents as a queue, flags as plain bits
  logic [7:0] q[$];
  logic [7:0] exp0[$];
  bit         m_ov = 0, m_un = 0, m_valid0 = 0;
  logic [7:0] m_last0 = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ov = 0; m_un = 0; m_valid0 = 0; m_last0 = 8'd0;
    end else if (flush) begin
      q.delete();
      m_valid0 = 0;
      if (clr_err) begin m_ov = 0; m_un = 0; end
    end else begin
      int sz;
      bit rd_ok, wr_ok;
      sz = q.size();
      rd_ok = rd_en && (sz != 0);
      wr_ok = wr_en && (sz != 4);
      if (wr_en && sz == 4) m_ov = 1; else if (clr_err) m_ov = 0;
      if (rd_en && sz == 0) m_un = 1; else if (clr_err) m_un = 0;
      if (rd_ok) begin
        m_last0 = q.pop_front();
        exp0.push_back(m_last0);
      end
      if (wr_ok) q.push_back(wr_data);
      m_valid0 = rd_ok;
    end
  end

  function automatic logic [8:0] exp_status();
    int n;
    n = q.size();
    return {3'(n), n == 0, n == 4, n <= 1, n >= 3, m_ov, m_un};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: compares outputs against the model away from the rising edge
  always @(negedge clk) begin
    check("status0", {level0, empty0, full0, ae0, af0, ov0, un0}, exp_status());
    check("status1", {level1, empty1, full1, ae1, af1, ov1, un1}, exp_status());
    check("rd_valid0", {8'd0, rd_valid0}, {8'd0, m_valid0});
    if (rd_valid0) begin
      if (exp0.size() == 0) check("rd_data0_unexpected", {1'b0, rd_data0}, 9'h1ff);
      else check("rd_data0", {1'b0, rd_data0}, {1'b0, exp0.pop_front()});
    end else begin
      check("rd_hold0", {1'b0, rd_data0}, {1'b0, m_last0});
    end
    check("rd_valid1", {8'd0, rd_valid1}, {8'd0, q.size() != 0});
    if (q.size() != 0) check("rd_data1", {1'b0, rd_data1}, {1'b0, q[0]});
  end

  task automatic step(input logic r, input logic f, input logic w, input logic [7:0] d,
                      input logic rd, input logic c);
    rst = r; flush = f; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
    @(negedge clk);
  endtask

  logic [7:0] seq[4];

  initial begin
    seq[0] = 8'd5; seq[1] = 8'd3; seq[2] = 8'd16; seq[3] = 8'd7;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // fill with 5,3,16,7
    for (int i = 0; i < 4; i++) step(0, 0, 1, seq[i], 0, 0);
    // overflow attempt, then clear
    step(0, 0, 1, 8'd9, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // drain plus one underflowing read
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // single word, then write while popping
    step(0, 0, 1, 8'd5, 0, 0);
    step(0, 0, 1, 8'd3, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // wrap-around with level kept in 1..3
    step(0, 0, 1, 8'($urandom), 0, 0);
    step(0, 0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom), 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // level 3 with a pending overflow flag, then flush alongside wr/rd
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'd40 + i), 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 8'd77, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset mid-stream
    step(0, 0, 1, 8'd11, 0, 0);
    step(0, 0, 1, 8'd12, 1, 0);
    step(1, 0, 1, 8'd13, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0));
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", 9'(exp0.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
